// File: rtl/bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// bcd_updown_counter
//
// Registered multi-digit BCD up/down counter. The digits form a carry/borrow
// chain: digit 0 always steps, and each higher digit steps only when every
// digit below it wrapped on the same step. A prescaler turns the enable into
// one count step every DIV enabled clocks. A parallel load sanitises each
// digit and records whether any digit was out of BCD range. A one-cycle
// terminal-count pulse marks a full wrap of the whole counter.
//
// Parameters:
//   DIGITS     number of BCD digits (1..4)
//   DIV        enabled clocks per count step (1..65535)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         count enable (en=0 holds the count and restarts the prescaler)
//   dir        1 = count up, 0 = count down, sampled on the tick edge
//   load       synchronous parallel load, takes priority over counting
//   load_data  BCD load value, digit 0 in bits [3:0]
//   count      registered BCD count, digit 0 in bits [3:0]
//   tc         one-cycle pulse, high with the first wrapped count
//   err        sticky flag: the last load held a non-BCD digit
// ---------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  err
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [4*DIGITS-1:0]  step_count;
  logic                 wrap;
  logic [4*DIGITS-1:0]  load_clean;
  logic                 load_bad;

  // A tick is the enabled edge on which the prescaler sits at its last value.
  assign tick = en && (div_cnt == DW'(DIV - 1));

  // Next count for one step in the sampled direction. The chain flag is the
  // carry/borrow into the current digit; if it survives past the top digit,
  // every digit wrapped and this step is a terminal-count wrap.
  always_comb begin
    logic       chain;
    logic [3:0] digit;
    logic [3:0] next_digit;
    logic       carry;
    chain      = 1'b1;
    digit      = 4'd0;
    next_digit = 4'd0;
    carry      = 1'b0;
    step_count = count;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (chain) begin
        if (dir) begin
          if (digit >= 4'd9) begin
            next_digit = 4'd0;
            carry      = 1'b1;
          end else begin
            next_digit = digit + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            next_digit = 4'd9;
            carry      = 1'b1;
          end else begin
            next_digit = digit - 4'd1;
            carry      = 1'b0;
          end
        end
        step_count[4*i +: 4] = next_digit;
        chain                = carry;
      end
    end
    wrap = chain;
  end

  // Out-of-range load digits become 0 so the count never holds a non-BCD
  // digit; the error flag remembers that it happened.
  always_comb begin
    load_clean = load_data;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_data[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
        load_bad             = 1'b1;
      end
    end
  end

  // State update: load beats a count step, which beats hold. Dropping en
  // restarts the prescaler so the next step needs a full DIV enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      tc      <= 1'b0;
      err     <= 1'b0;
      div_cnt <= '0;
    end else if (load) begin
      count   <= load_clean;
      err     <= load_bad;
      tc      <= 1'b0;
      div_cnt <= '0;
    end else if (tick) begin
      count   <= step_count;
      tc      <= wrap;
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + DW'(1);
      tc      <= 1'b0;
    end else begin
      div_cnt <= '0;
      tc      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Drives two counters (DIV=1 and DIV=3, both two digits) from shared inputs.
// Directed scenario tasks check known count sequences; a randomized scenario
// compares both counters against an integer reference model that counts
// modulo 100 and converts to BCD only for comparison.
// ---------------------------------------------------------------------------
module tb_bcd_updown_counter;

  localparam int MOD = 100;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] count1;
  logic       tc1;
  logic       err1;
  logic [7:0] count3;
  logic       tc3;
  logic       err3;

  int checks;
  int fails;

  // reference model state, index 0 = DIV 1, index 1 = DIV 3
  int m_val [2];
  int m_div [2];
  bit m_tc  [2];
  bit m_err [2];

  bcd_updown_counter #(.DIGITS(2), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_data(load_data), .count(count1), .tc(tc1), .err(err1)
  );

  bcd_updown_counter #(.DIGITS(2), .DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_data(load_data), .count(count3), .tc(tc3), .err(err3)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  function automatic int load_value(input logic [7:0] d);
    int hi;
    int lo;
    hi = int'(d[7:4]);
    lo = int'(d[3:0]);
    if (hi > 9) hi = 0;
    if (lo > 9) lo = 0;
    return hi * 10 + lo;
  endfunction

  // reference model: plain modulo-100 arithmetic plus a step counter
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      int ratio;
      ratio = (k == 0) ? 1 : 3;
      if (!rst_n) begin
        m_val[k] = 0;
        m_div[k] = 0;
        m_tc[k]  = 1'b0;
        m_err[k] = 1'b0;
      end else if (load) begin
        m_val[k] = load_value(load_data);
        m_err[k] = (load_data[7:4] > 4'd9) || (load_data[3:0] > 4'd9);
        m_div[k] = 0;
        m_tc[k]  = 1'b0;
      end else if (en) begin
        m_div[k] = m_div[k] + 1;
        m_tc[k]  = 1'b0;
        if (m_div[k] == ratio) begin
          m_div[k] = 0;
          if (dir) begin
            m_tc[k]  = (m_val[k] == MOD - 1);
            m_val[k] = (m_val[k] + 1) % MOD;
          end else begin
            m_tc[k]  = (m_val[k] == 0);
            m_val[k] = (m_val[k] + MOD - 1) % MOD;
          end
        end
      end else begin
        m_div[k] = 0;
        m_tc[k]  = 1'b0;
      end
    end
  end

  // drive one cycle of inputs at a falling edge and wait for the next one
  task automatic applyStimulus(input logic e, input logic d, input logic l,
                               input logic [7:0] ld);
    en        = e;
    dir       = d;
    load      = l;
    load_data = ld;
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h37);
    checks++;
    if (count1 !== 8'h37) begin
      fails++;
      $display("[TB] FAIL reset_preload: count=%h expected=37", count1);
    end
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count1 !== 8'h00 || tc1 !== 1'b0 || err1 !== 1'b0 ||
        count3 !== 8'h00 || tc3 !== 1'b0 || err3 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: count1=%h tc1=%b err1=%b count3=%h expected 00/0/0",
               count1, tc1, err1, count3);
    end
    #1 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (count1 !== 8'h00 || tc1 !== 1'b0 || count3 !== 8'h00 || tc3 !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_hold cycle %0d: count1=%h tc1=%b count3=%h expected 00/0",
                 c, count1, tc1, count3);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_cnt [4];
    logic       exp_tc  [4];
    exp_cnt = '{8'h98, 8'h99, 8'h00, 8'h01};
    exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h97);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checks++;
      if (count1 !== exp_cnt[c] || tc1 !== exp_tc[c]) begin
        fails++;
        $display("[TB] FAIL up_wrap step %0d: count=%h tc=%b expected %h/%b",
                 c, count1, tc1, exp_cnt[c], exp_tc[c]);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h09);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (count1 !== 8'h10 || tc1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL up_carry: count=%h tc=%b expected 10/0", count1, tc1);
    end
  endtask

  task automatic test_down_wrap();
    logic [7:0] exp_cnt [3];
    logic       exp_tc  [3];
    exp_cnt = '{8'h00, 8'h99, 8'h98};
    exp_tc  = '{1'b0, 1'b1, 1'b0};
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (count1 !== exp_cnt[c] || tc1 !== exp_tc[c]) begin
        fails++;
        $display("[TB] FAIL down_wrap step %0d: count=%h tc=%b expected %h/%b",
                 c, count1, tc1, exp_cnt[c], exp_tc[c]);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (count1 !== 8'h09 || tc1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL down_borrow: count=%h tc=%b expected 09/0", count1, tc1);
    end
  endtask

  task automatic test_prescaler();
    logic [7:0] exp_cnt [11];
    logic       en_seq  [11];
    exp_cnt = '{8'h05, 8'h05, 8'h06, 8'h06, 8'h06, 8'h07,
                8'h07, 8'h07, 8'h07, 8'h07, 8'h08};
    en_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h05);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(en_seq[c], 1'b1, 1'b0, 8'h00);
      checks++;
      if (count3 !== exp_cnt[c] || tc3 !== 1'b0) begin
        fails++;
        $display("[TB] FAIL prescaler edge %0d: count=%h tc=%b expected %h/0",
                 c + 1, count3, tc3, exp_cnt[c]);
      end
    end
  endtask

  task automatic test_illegal_load();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA4);
    checks++;
    if (count1 !== 8'h04 || err1 !== 1'b1 || count3 !== 8'h04 || err3 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL illegal_load: count1=%h err1=%b count3=%h err3=%b expected 04/1",
               count1, err1, count3, err3);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (count1 !== 8'h06 || err1 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL err_sticky: count=%h err=%b expected 06/1", count1, err1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h12);
    checks++;
    if (count1 !== 8'h12 || err1 !== 1'b0 || err3 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL err_clear: count=%h err1=%b err3=%b expected 12/0",
               count1, err1, err3);
    end
  endtask

  task automatic test_load_vs_en();
    logic       dir_seq [3];
    logic [7:0] exp1    [3];
    logic [7:0] exp3    [3];
    dir_seq = '{1'b1, 1'b0, 1'b1};
    exp1    = '{8'h51, 8'h50, 8'h51};
    exp3    = '{8'h50, 8'h50, 8'h51};
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h50);
    checks++;
    if (count1 !== 8'h50 || count3 !== 8'h50 || tc1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL load_wins: count1=%h count3=%h tc1=%b expected 50/50/0",
               count1, count3, tc1);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, dir_seq[c], 1'b0, 8'h00);
      checks++;
      if (count1 !== exp1[c] || count3 !== exp3[c]) begin
        fails++;
        $display("[TB] FAIL dir_sample step %0d: count1=%h count3=%h expected %h/%h",
                 c, count1, count3, exp1[c], exp3[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic e;
      logic d;
      logic l;
      logic [7:0] ld;
      e  = ($urandom_range(0, 9) < 8);
      d  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 15) == 0);
      ld = 8'($urandom);
      en        = e;
      dir       = d;
      load      = l;
      load_data = ld;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (count1 !== to_bcd(m_val[0]) || tc1 !== m_tc[0] || err1 !== m_err[0]) begin
        fails++;
        $display("[TB] FAIL random_div1 cycle %0d: count=%h tc=%b err=%b expected %h/%b/%b",
                 c, count1, tc1, err1, to_bcd(m_val[0]), m_tc[0], m_err[0]);
      end
      checks++;
      if (count3 !== to_bcd(m_val[1]) || tc3 !== m_tc[1] || err3 !== m_err[1]) begin
        fails++;
        $display("[TB] FAIL random_div3 cycle %0d: count=%h tc=%b err=%b expected %h/%b/%b",
                 c, count3, tc3, err3, to_bcd(m_val[1]), m_tc[1], m_err[1]);
      end
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0;
      m_div[k] = 0;
      m_tc[k]  = 1'b0;
      m_err[k] = 1'b0;
    end
    rst_n     = 1'b0;
    en        = 1'b0;
    dir       = 1'b0;
    load      = 1'b0;
    load_data = 8'h00;
    #12 rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] starting scenarios");
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_prescaler();
    test_illegal_load();
    test_load_vs_en();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
